lcd_escritor: RTL and testbench
===============================

LCD_ESCRITOR -- requirements
Module: lcd_escritor

Interface
REQ-001 Parameter POWERUP_CYC, default 1000000, SHALL set the power-on wait in clock cycles (20 ms at 50 MHz).
REQ-002 Parameter E_HIGH_CYC, default 25, SHALL set the enable-high width in cycles.
REQ-003 Parameter CMD_WAIT_CYC, default 2500, SHALL set the post-byte wait in cycles for ordinary bytes.
REQ-004 Parameter CLEAR_WAIT_CYC, default 100000, SHALL set the post-byte wait in cycles after command 0x01 or 0x02.
REQ-005 clk  in  1  single system clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  request to write one frame; sampled only in IDLE.
REQ-008 palavra  in  144  frame of 18 bytes; byte i = palavra[8i+7:8i], i = 0..17.
REQ-009 RS_list  in  18  RS per byte; RS_list[i] belongs to byte i (1 = data, 0 = command).
REQ-010 lcd_data  out  8  HD44780 data bus.
REQ-011 lcd_rs  out  1  HD44780 register select.
REQ-012 lcd_rw  out  1  HD44780 read/write; constant 0.
REQ-013 lcd_e  out  1  HD44780 enable strobe.
REQ-014 ready  out  1  high only in IDLE.
REQ-015 done  out  1  one-cycle pulse when a frame completes.

Function
REQ-016 States SHALL be POWERUP, INIT, IDLE, LOAD, SETUP, EHIGH, WAIT, DONE.
REQ-017 POWERUP SHALL count POWERUP_CYC cycles with lcd_e=0, then enter INIT.
REQ-018 INIT SHALL send 0x38, 0x0C, 0x06, 0x01 in that order, RS=0, each via the byte cycle of REQ-020, then enter IDLE.
REQ-019 In IDLE with start=1, the block SHALL latch palavra and RS_list into internal registers in the same edge (LOAD) and set the byte index to 0.
REQ-020 Byte cycle: SETUP 1 cycle (lcd_data and lcd_rs driven, lcd_e=0); EHIGH E_HIGH_CYC cycles (lcd_e=1, lcd_data and lcd_rs unchanged); WAIT N cycles (lcd_e=0, lcd_data and lcd_rs held).
REQ-021 N SHALL be CLEAR_WAIT_CYC when RS=0 and byte is 0x01 or 0x02, otherwise CMD_WAIT_CYC.
REQ-022 Frame bytes SHALL be sent in index order 0..17, with RS taken from the latched RS_list bit of the same index.
REQ-023 After WAIT of byte 17, the block SHALL enter DONE for exactly one cycle (done=1), then return to IDLE.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Input changes after LOAD SHALL NOT affect the frame in progress.
REQ-026 start held high SHALL begin a new frame on the first IDLE cycle after DONE.
REQ-027 The byte index SHALL be 5 bits and SHALL never exceed 17.
REQ-028 Wait counters SHALL be wide enough for the largest parameter, so no counter wraps.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst=1, the block SHALL hold state POWERUP, all counters 0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, ready=0, done=0.
REQ-031 rst asserted mid-byte or mid-frame SHALL drop lcd_e immediately, discard the frame, and rerun POWERUP and INIT after release.

Verification
Bench parameters: POWERUP_CYC=10, E_HIGH_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8.
REQ-032 Release rst -> lcd_e stays 0 for 10 cycles; then four E pulses with bytes 38,0C,06,01 and RS=0; gap after 01 is 8 cycles; ready rises after that.
REQ-033 Frame "LOAD" (opcode LOAD frame, byte4=0x89, RS_list[4]=0, RS_list[11]=0) plus start -> 18 E pulses, each 2 cycles wide, bytes in order 4C,4F,41,44,89,...; lcd_rs low exactly on bytes 4 and 11; done pulses once; ready=1 on the next cycle.
REQ-034 ADD-style frame with byte17=0x02, RS=0 -> wait after byte 17 is 8 cycles; all other waits are 4 cycles; total frame = 17*7 + 11 + 1 cycles from LOAD to DONE.
REQ-035 Pulse start again and change palavra mid-frame -> second start ignored; emitted bytes match the latched frame.
REQ-036 Assert rst during EHIGH of byte 9 -> lcd_e=0 asynchronously; after release the full POWERUP/INIT sequence repeats and no done pulse occurs.
REQ-037 CLEAR frame (bytes 5..17 = 0x02, RS=0) -> thirteen consecutive 8-cycle waits; lcd_rw=0 throughout.

Source files
------------

// File: rtl/lcd_escritor.sv
// HD44780 8-bit writer: power-up wait, fixed init sequence, then 18-byte frames on start.
// state   | meaning
// POWERUP | wait POWERUP_CYC cycles after reset, lcd_e low
// INIT    | present next init command (38,0C,06,01)
// IDLE    | ready, waiting for start
// LOAD    | frame and RS bits latched, byte index at 0
// SETUP   | data/rs driven, lcd_e low
// EHIGH   | lcd_e high for E_HIGH_CYC cycles
// WAIT    | post-byte wait (long after clear/home commands)
// DONE    | one-cycle done pulse
module lcd_escritor #(
  parameter int POWERUP_CYC    = 1000000,
  parameter int E_HIGH_CYC     = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [143:0] palavra,
  input  logic [17:0]  RS_list,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         ready,
  output logic         done
);

  localparam int MAX_A   = (POWERUP_CYC > E_HIGH_CYC) ? POWERUP_CYC : E_HIGH_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {POWERUP, INIT, IDLE, LOAD, SETUP, EHIGH, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, wait_last;
  logic [4:0]         idx, idx_nxt;
  logic [1:0]         init_idx, init_idx_nxt;
  logic               init_mode, init_mode_nxt;
  logic [143:0]       frame;
  logic [17:0]        rs_frame;
  logic [7:0]         data_nxt, init_byte;
  logic               rs_nxt, latch;

  assign lcd_rw = 1'b0;

  always_comb begin
    case (init_idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  // Clear (0x01) and return-home (0x02) commands need the long settle time.
  always_comb begin
    if (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02))
      wait_last = CNT_W'(CLEAR_WAIT_CYC - 1);
    else
      wait_last = CNT_W'(CMD_WAIT_CYC - 1);
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    init_idx_nxt  = init_idx;
    init_mode_nxt = init_mode;
    data_nxt      = lcd_data;
    rs_nxt        = lcd_rs;
    latch         = 1'b0;
    case (state)
      POWERUP: begin
        if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
          cnt_nxt       = '0;
          init_idx_nxt  = 2'd0;
          init_mode_nxt = 1'b1;
          state_nxt     = INIT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      INIT: begin
        data_nxt  = init_byte;
        rs_nxt    = 1'b0;
        state_nxt = SETUP;
      end
      IDLE: begin
        if (start) begin
          latch     = 1'b1;
          idx_nxt   = 5'd0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        data_nxt  = frame[7:0];
        rs_nxt    = rs_frame[0];
        state_nxt = SETUP;
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = EHIGH;
      end
      EHIGH: begin
        if (cnt == CNT_W'(E_HIGH_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt == wait_last) begin
          cnt_nxt = '0;
          if (init_mode) begin
            if (init_idx == 2'd3) begin
              init_mode_nxt = 1'b0;
              state_nxt     = IDLE;
            end else begin
              init_idx_nxt = init_idx + 2'd1;
              state_nxt    = INIT;
            end
          end else if (idx == 5'd17) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 5'd1;
            data_nxt  = frame[{idx_nxt, 3'b000} +: 8];
            rs_nxt    = rs_frame[idx_nxt];
            state_nxt = SETUP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = POWERUP;
    endcase
  end

  // Strobe/status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= POWERUP;
      cnt       <= '0;
      idx       <= '0;
      init_idx  <= '0;
      init_mode <= 1'b0;
      frame     <= '0;
      rs_frame  <= '0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      init_idx  <= init_idx_nxt;
      init_mode <= init_mode_nxt;
      lcd_data  <= data_nxt;
      lcd_rs    <= rs_nxt;
      lcd_e     <= (state_nxt == EHIGH);
      ready     <= (state_nxt == IDLE);
      done      <= (state_nxt == DONE);
      if (latch) begin
        frame    <= palavra;
        rs_frame <= RS_list;
      end
    end
  end

endmodule

// File: tb/tb_lcd_escritor.sv
// Self-checking bench for lcd_escritor: expected bytes/gaps queued at stimulus, popped per E pulse.
module tb_lcd_escritor;
  localparam int PU = 10, EH = 2, CW = 4, CLW = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [143:0] palavra;
  logic [17:0]  RS_list;
  logic [7:0]   lcd_data;
  logic         lcd_rs, lcd_rw, lcd_e, ready, done;

  int total = 0, bad = 0;
  int cyc = 0, rw_bad = 0, done_cnt = 0;

  typedef struct {logic [7:0] d; logic rs; int gap;} exp_t;
  typedef struct {logic [143:0] pal; logic [17:0] rs; int frame_cyc;} vec_t;
  exp_t sbq[$];
  vec_t vecs[3];

  lcd_escritor #(.POWERUP_CYC(PU), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW)) dut (
    .clk(clk), .rst(rst), .start(start), .palavra(palavra), .RS_list(RS_list),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .ready(ready), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    logic [7:0] ib [4];
    exp_t e;
    int n;
    ib = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++) begin
      n = (ib[i] == 8'h01 || ib[i] == 8'h02) ? CLW : CW;
      e.d = ib[i]; e.rs = 1'b0;
      e.gap = (i == 3) ? n : n + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [143:0] p, input logic [17:0] r);
    exp_t e;
    int n;
    for (int i = 0; i < 18; i++) begin
      e.d = p[8*i +: 8]; e.rs = r[i];
      n = (!e.rs && (e.d == 8'h01 || e.d == 8'h02)) ? CLW : CW;
      e.gap = (i == 17) ? n : n + 1;
      sbq.push_back(e);
    end
  endtask

  // Pops one expectation per E pulse: data/rs at rise, pulse width, low gap after it.
  task automatic drain();
    exp_t e;
    int n, hi, lo, moved;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n = 0;
      while (lcd_e !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) begin
        chk("e_rise_timeout", 32'(n), 32'd0);
        sbq.delete();
        return;
      end
      chk("byte_data", {24'd0, lcd_data}, {24'd0, e.d});
      chk("byte_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
      hi = 0; moved = 0;
      while (lcd_e === 1'b1 && hi < 50) begin
        if (lcd_data !== e.d || lcd_rs !== e.rs) moved++;
        hi++;
        @(negedge clk);
      end
      chk("e_width", 32'(hi), 32'(EH));
      chk("bus_stable_e_high", 32'(moved), 32'd0);
      lo = 0;
      while (lcd_e === 1'b0 && done !== 1'b1 && ready !== 1'b1 && lo < 400) begin
        lo++;
        @(negedge clk);
      end
      chk("gap_after_byte", 32'(lo), 32'(e.gap));
    end
  endtask

  task automatic do_init();
    int viol = 0;
    for (int i = 0; i < PU; i++) begin
      @(negedge clk);
      if (lcd_e !== 1'b0) viol++;
    end
    chk("powerup_e_low", 32'(viol), 32'd0);
    push_init();
    drain();
    chk("init_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic start_frame(input vec_t v, input logic hold, output int t0);
    palavra = v.pal;
    RS_list = v.rs;
    start   = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if (!hold) start = 1'b0;
    push_frame(v.pal, v.rs);
  endtask

  task automatic finish_frame(input int t0, input int exp_cyc);
    drain();
    chk("done_high", {31'd0, done}, 32'd1);
    chk("frame_cycles", 32'(cyc - t0), 32'(exp_cyc));
    @(negedge clk);
    chk("done_low_ready", {30'd0, done, ready}, 32'b01);
  endtask

  initial begin
    logic [143:0] p;
    logic [17:0]  r;
    int t0, rises, n, dcnt, viol;
    logic prev;

    // LOAD-style frame: "LOAD", opcode 0x89 as command, byte 11 command 0xC0
    for (int i = 0; i < 18; i++) p[8*i +: 8] = 8'h41 + 8'(i);
    p[7:0] = 8'h4C; p[15:8] = 8'h4F; p[23:16] = 8'h41; p[31:24] = 8'h44;
    p[39:32] = 8'h89; p[95:88] = 8'hC0;
    r = 18'h3FFFF; r[4] = 1'b0; r[11] = 1'b0;
    vecs[0] = '{pal: p, rs: r, frame_cyc: 1 + 18*7};
    // ADD-style frame ending in return-home command
    for (int i = 0; i < 18; i++) p[8*i +: 8] = 8'h30 + 8'(i);
    p[143:136] = 8'h02;
    r = 18'h3FFFF; r[17] = 1'b0;
    vecs[1] = '{pal: p, rs: r, frame_cyc: 17*7 + 11 + 1};
    // CLEAR frame: bytes 5..17 are 0x02 commands
    for (int i = 0; i < 18; i++) p[8*i +: 8] = (i < 5) ? 8'h61 + 8'(i) : 8'h02;
    r = 18'h0001F;
    vecs[2] = '{pal: p, rs: r, frame_cyc: 1 + 5*7 + 13*11};

    rst = 1'b1; start = 1'b0; palavra = '0; RS_list = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'd0, lcd_data, lcd_rs, lcd_rw, lcd_e, ready, done}, 32'd0);
    rst = 1'b0;
    do_init();

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_frame(vecs[k], 1'b0, t0);
      finish_frame(t0, vecs[k].frame_cyc);
    end

    // second start and input changes mid-frame are ignored
    @(negedge clk);
    start_frame(vecs[1], 1'b0, t0);
    fork
      finish_frame(t0, vecs[1].frame_cyc);
      begin
        repeat (20) @(negedge clk);
        start = 1'b1; palavra = ~palavra; RS_list = ~RS_list;
        @(negedge clk);
        start = 1'b0;
      end
    join
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lcd_e !== 1'b0 || ready !== 1'b1) viol++;
    end
    chk("idle_after_ignored_start", 32'(viol), 32'd0);

    // start held high restarts on the first IDLE cycle after DONE
    start_frame(vecs[0], 1'b1, t0);
    finish_frame(t0, vecs[0].frame_cyc);
    @(negedge clk);
    chk("held_start_reload", {31'd0, ready}, 32'd0);
    t0 = cyc;
    start = 1'b0;
    push_frame(vecs[0].pal, vecs[0].rs);
    finish_frame(t0, vecs[0].frame_cyc);

    // reset during EHIGH of byte 9
    @(negedge clk);
    start_frame(vecs[0], 1'b0, t0);
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 10 && n < 300) begin
      @(negedge clk);
      if (lcd_e === 1'b1 && prev === 1'b0) rises++;
      prev = lcd_e;
      n++;
    end
    chk("byte9_reached", 32'(rises), 32'd10);
    sbq.delete();
    dcnt = done_cnt;
    #1 rst = 1'b1;
    #1 chk("rst_drops_e_async", {31'd0, lcd_e}, 32'd0);
    @(negedge clk);
    chk("reset_outputs_mid", {19'd0, lcd_data, lcd_rs, lcd_rw, lcd_e, ready, done}, 32'd0);
    rst = 1'b0;
    do_init();
    chk("no_done_after_rst", 32'(done_cnt), 32'(dcnt));

    @(negedge clk);
    start_frame(vecs[2], 1'b0, t0);
    finish_frame(t0, vecs[2].frame_cyc);

    chk("rw_always_low", 32'(rw_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
